// File: rtl/jt9346_ctrl.sv
// jt9346_ctrl: host-side controller for 93C46/96C06-style serial EEPROMs.
// Turns one-word bus commands into start/opcode/address/data frames on
// sclk/scs/sdi, shifts READ data back in from sdo and polls ready/busy
// after write-type commands.
module jt9346_ctrl #(
  parameter int AW      = 6,
  parameter int DW      = 16,
  parameter int CLKDIV  = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_din,
  input  logic          cmd_start,
  output logic          cmd_busy,
  output logic          cmd_done,
  output logic          cmd_err,
  output logic [DW-1:0] cmd_dout,
  output logic          sclk,
  output logic          scs,
  output logic          sdi,
  input  logic          sdo
);

  localparam int FW   = 3 + AW + DW;
  localparam int DIVW = $clog2(CLKDIV);
  localparam int BCW  = $clog2(FW + 1);
  localparam int PMAX = (TIMEOUT > 3) ? TIMEOUT : 3;
  localparam int PCW  = $clog2(PMAX + 1);

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_EWDS  = 3'd4;
  localparam logic [2:0] OP_ERAL  = 3'd5;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  localparam logic [DIVW-1:0] DIV_LAST  = DIVW'(CLKDIV - 1);
  localparam logic [BCW-1:0]  HDR_BITS  = BCW'(3 + AW);
  localparam logic [BCW-1:0]  ALL_BITS  = BCW'(FW);
  localparam logic [BCW-1:0]  RD_LAST   = BCW'(DW - 1);
  localparam logic [PCW-1:0]  POLL_MAX  = PCW'(TIMEOUT);
  localparam logic [PCW-1:0]  POLL_SKIP = PCW'(2);

  typedef enum logic [2:0] {
    IDLE, SHIFT, RDATA, GAP, POLL, FINISH
  } state_t;

  state_t          state, state_nx;
  logic [DIVW-1:0] div_cnt;
  logic [BCW-1:0]  bit_cnt;
  logic [BCW-1:0]  nbits;
  logic [PCW-1:0]  poll_cnt;
  logic [FW-1:0]   shreg;
  logic [2:0]      op_l;
  logic            err_l;

  logic [1:0]      opc;
  logic [AW-1:0]   addr_f;
  logic [DW-1:0]   data_f;
  logic [FW-1:0]   frame;
  logic            long_cmd;
  logic            accept;
  logic            div_end;
  logic            fall;
  logic            shift_last;
  logic            rd_last;
  logic            poll_ready;

  // Build the outgoing frame from the live command inputs, left-aligned with the start bit at the top
  always_comb begin
    opc      = 2'b00;
    addr_f   = cmd_addr;
    data_f   = '0;
    long_cmd = 1'b0;
    case (cmd_op)
      OP_READ:  opc = 2'b10;
      OP_WRITE: begin
        opc      = 2'b01;
        data_f   = cmd_din;
        long_cmd = 1'b1;
      end
      OP_ERASE: opc = 2'b11;
      OP_EWEN: begin
        addr_f = '0;
        addr_f[AW-1 -: 2] = 2'b11;
      end
      OP_EWDS: addr_f = '0;
      OP_ERAL: begin
        addr_f = '0;
        addr_f[AW-1 -: 2] = 2'b10;
      end
      OP_WRAL: begin
        addr_f = '0;
        addr_f[AW-1 -: 2] = 2'b01;
        data_f   = cmd_din;
        long_cmd = 1'b1;
      end
      default: ;
    endcase
    frame = {1'b1, opc, addr_f, data_f};
  end

  // Timing strobes shared by the state machine and the datapath
  always_comb begin
    accept     = (state == IDLE) && cmd_start && !cmd_busy;
    div_end    = (div_cnt == DIV_LAST);
    fall       = div_end && sclk;
    shift_last = fall && (bit_cnt == nbits - BCW'(1));
    rd_last    = fall && (bit_cnt == RD_LAST);
    poll_ready = (poll_cnt >= POLL_SKIP) && sdo;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic: reads continue into RDATA, EWEN/EWDS need no ready poll
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:   if (accept) state_nx = (cmd_op == OP_RSVD) ? FINISH : SHIFT;
      SHIFT: begin
        if (shift_last) begin
          if (op_l == OP_READ)                         state_nx = RDATA;
          else if (op_l == OP_EWEN || op_l == OP_EWDS) state_nx = FINISH;
          else                                         state_nx = GAP;
        end
      end
      RDATA:  if (rd_last) state_nx = FINISH;
      GAP:    if (div_end) state_nx = POLL;
      POLL:   if (poll_ready || poll_cnt == POLL_MAX) state_nx = FINISH;
      FINISH: state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: sclk divider, frame shifter, read capture, poll counter and registered pins
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_cnt  <= '0;
      bit_cnt  <= '0;
      nbits    <= '0;
      poll_cnt <= '0;
      shreg    <= '0;
      op_l     <= '0;
      err_l    <= 1'b0;
      cmd_busy <= 1'b0;
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      cmd_dout <= '0;
      sclk     <= 1'b0;
      scs      <= 1'b0;
      sdi      <= 1'b0;
    end else begin
      cmd_done <= 1'b0;
      cmd_err  <= 1'b0;
      case (state)
        IDLE: begin
          div_cnt <= '0;
          bit_cnt <= '0;
          if (accept) begin
            op_l     <= cmd_op;
            err_l    <= (cmd_op == OP_RSVD);
            cmd_busy <= 1'b1;
            nbits    <= long_cmd ? ALL_BITS : HDR_BITS;
            if (cmd_op != OP_RSVD) begin
              scs   <= 1'b1;
              sdi   <= frame[FW-1];
              shreg <= frame << 1;
            end
          end
        end
        SHIFT, RDATA: begin
          if (div_end) begin
            div_cnt <= '0;
            sclk    <= ~sclk;
            if (sclk) begin
              if (state == SHIFT) begin
                if (shift_last) begin
                  bit_cnt <= '0;
                  sdi     <= 1'b0;
                  if (state_nx == GAP) scs <= 1'b0;
                end else begin
                  bit_cnt <= bit_cnt + BCW'(1);
                  sdi     <= shreg[FW-1];
                  shreg   <= shreg << 1;
                end
              end else begin
                shreg   <= {shreg[FW-2:0], sdo};
                bit_cnt <= rd_last ? '0 : bit_cnt + BCW'(1);
              end
            end
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        GAP: begin
          if (div_end) begin
            div_cnt  <= '0;
            scs      <= 1'b1;
            poll_cnt <= '0;
          end else begin
            div_cnt <= div_cnt + DIVW'(1);
          end
        end
        POLL: begin
          if (!poll_ready && poll_cnt == POLL_MAX) err_l <= 1'b1;
          if (poll_cnt != POLL_MAX) poll_cnt <= poll_cnt + PCW'(1);
        end
        FINISH: begin
          scs      <= 1'b0;
          sclk     <= 1'b0;
          sdi      <= 1'b0;
          cmd_busy <= 1'b0;
          cmd_done <= 1'b1;
          cmd_err  <= err_l;
          div_cnt  <= '0;
          bit_cnt  <= '0;
          if (op_l == OP_READ && !err_l) cmd_dout <= shreg[DW-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_jt9346_ctrl.sv
// tb_jt9346_ctrl: directed bench for jt9346_ctrl with a small behavioural
// 93C46 model (64 x 16) and a scoreboard of expected command results.
module tb_jt9346_ctrl;

  localparam int AW      = 6;
  localparam int DW      = 16;
  localparam int CLKDIV  = 4;
  localparam int TIMEOUT = 300;

  localparam logic [2:0] OP_READ  = 3'd0;
  localparam logic [2:0] OP_WRITE = 3'd1;
  localparam logic [2:0] OP_ERASE = 3'd2;
  localparam logic [2:0] OP_EWEN  = 3'd3;
  localparam logic [2:0] OP_WRAL  = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [2:0]    cmd_op = '0;
  logic [AW-1:0] cmd_addr = '0;
  logic [DW-1:0] cmd_din = '0;
  logic          cmd_start = 1'b0;
  logic          cmd_busy, cmd_done, cmd_err;
  logic [DW-1:0] cmd_dout;
  logic          sclk, scs, sdi, sdo;

  int   n_assert = 0;
  int   n_fail   = 0;
  int   cyc, lat, scs_rises, extra_done;
  logic prev_scs;

  typedef struct packed {
    logic [DW-1:0] dout;
    logic          err;
    logic          chk;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;

  jt9346_ctrl #(.AW(AW), .DW(DW), .CLKDIV(CLKDIV), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_din(cmd_din), .cmd_start(cmd_start),
    .cmd_busy(cmd_busy), .cmd_done(cmd_done), .cmd_err(cmd_err), .cmd_dout(cmd_dout),
    .sclk(sclk), .scs(scs), .sdi(sdi), .sdo(sdo)
  );

  // EEPROM model state
  logic [DW-1:0] mem [0:63];
  logic          mem_init = 1'b1;
  logic          ew_en = 1'b0;
  logic          sclk_q = 1'b0;
  logic          scs_q = 1'b0;
  logic          rd_active = 1'b0;
  logic          m_sdo = 1'b0;
  logic          sdo_force0 = 1'b0;
  logic [24:0]   rx = '0;
  int            rx_cnt = 0;
  int            busy_cnt = 0;
  logic [DW-1:0] rd_sh = '0;
  logic [8:0]    hdr;

  assign sdo = sdo_force0 ? 1'b0 : (rd_active ? m_sdo : (busy_cnt == 0));

  // Behavioural EEPROM: shifts sdi on sclk rises, drives read data, programs on scs fall
  always @(posedge clk) begin
    sclk_q <= sclk;
    scs_q  <= scs;
    if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    if (mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= 16'h1000 + 16'(i);
      ew_en     <= 1'b0;
      rx_cnt    <= 0;
      rd_active <= 1'b0;
      busy_cnt  <= 0;
    end else if (scs && !scs_q) begin
      rx_cnt    <= 0;
      rd_active <= 1'b0;
    end else if (!scs && scs_q) begin
      rd_active <= 1'b0;
      rx_cnt    <= 0;
      if (ew_en && rx_cnt == 9 && rx[8] && rx[7:6] == 2'b11) begin
        mem[rx[5:0]] <= 16'hFFFF;
        busy_cnt     <= 30;
      end
      if (ew_en && rx_cnt == 9 && rx[8:4] == 5'b10010) begin
        for (int i = 0; i < 64; i++) mem[i] <= 16'hFFFF;
        busy_cnt <= 30;
      end
      if (ew_en && rx_cnt == 25 && rx[24:22] == 3'b101) begin
        mem[rx[21:16]] <= rx[15:0];
        busy_cnt       <= 30;
      end
      if (ew_en && rx_cnt == 25 && rx[24:20] == 5'b10001) begin
        for (int i = 0; i < 64; i++) mem[i] <= rx[15:0];
        busy_cnt <= 30;
      end
    end else if (scs && sclk && !sclk_q) begin
      if (rd_active) begin
        m_sdo <= rd_sh[DW-1];
        rd_sh <= rd_sh << 1;
      end else begin
        rx     <= {rx[23:0], sdi};
        rx_cnt <= rx_cnt + 1;
        if (rx_cnt == 8) begin
          hdr = {rx[7:0], sdi};
          if (hdr[8:6] == 3'b110) begin
            rd_active <= 1'b1;
            rd_sh     <= mem[hdr[5:0]];
            m_sdo     <= 1'b0;
          end
          if (hdr[8:4] == 5'b10011) ew_en <= 1'b1;
          if (hdr[8:4] == 5'b10000) ew_en <= 1'b0;
        end
      end
    end
  end

  int         rise_cnt = 0;
  logic [8:0] first_bits = '0;

  // Record sdi at the first nine sclk rises of each frame and count rises
  always @(posedge clk) begin
    if (scs && !scs_q) rise_cnt <= 0;
    else if (sclk && !sclk_q) begin
      if (rise_cnt < 9) first_bits[8 - rise_cnt] <= sdi;
      rise_cnt <= rise_cnt + 1;
    end
  end

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [2:0] op, input logic [AW-1:0] addr, input logic [DW-1:0] din);
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_din   = din;
    cmd_start = 1'b1;
    @(negedge clk);
    cmd_start = 1'b0;
    cyc       = 1;
    scs_rises = scs ? 1 : 0;
    prev_scs  = scs;
  endtask

  task automatic wait_done(input string tag, input int poke);
    bit   seen;
    exp_t e;
    seen = cmd_done;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      cmd_start = (cyc == poke);
      if (scs && !prev_scs) scs_rises++;
      prev_scs = scs;
      seen = cmd_done;
    end
    cmd_start = 1'b0;
    lat = cyc - 1;
    check_output({tag, " done"}, 32'(seen), 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
      if (seen) begin
        check_output({tag, " busy"}, 32'(cmd_busy), 32'd0);
        check_output({tag, " err"}, 32'(cmd_err), 32'(e.err));
        if (e.chk) check_output({tag, " dout"}, 32'(cmd_dout), 32'(e.dout));
      end
    end
  endtask

  task automatic run_cmd(input string tag, input logic [2:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] din, input logic [DW-1:0] exp_dout,
                         input logic exp_err, input logic chk);
    sb.push_back('{dout: exp_dout, err: exp_err, chk: chk});
    apply_stimulus(op, addr, din);
    wait_done(tag, 0);
  endtask

  initial begin
    $display("[TB] jt9346_ctrl bench start");
    repeat (3) @(negedge clk);
    mem_init = 1'b0;
    rst      = 1'b0;
    @(negedge clk);
    check_output("reset sclk", 32'(sclk), 0);
    check_output("reset scs", 32'(scs), 0);
    check_output("reset sdi", 32'(sdi), 0);
    check_output("reset busy", 32'(cmd_busy), 0);
    check_output("reset done", 32'(cmd_done), 0);
    check_output("reset err", 32'(cmd_err), 0);
    check_output("reset dout", 32'(cmd_dout), 0);

    run_cmd("read 2A", OP_READ, 6'h2A, '0, 16'h102A, 1'b0, 1'b1);
    check_output("read 2A latency", 32'(lat), 32'(25 * 2 * CLKDIV + 1));
    check_output("read 2A header bits", 32'(first_bits), 32'h1AA);
    check_output("read 2A sclk pulses", 32'(rise_cnt), 32'd25);
    check_output("read 2A scs rises", 32'(scs_rises), 32'd1);

    run_cmd("ewen", OP_EWEN, '0, '0, '0, 1'b0, 1'b0);
    check_output("ewen latency", 32'(lat), 32'(9 * 2 * CLKDIV + 1));
    run_cmd("write 05", OP_WRITE, 6'h05, 16'hA55A, '0, 1'b0, 1'b0);
    check_output("write 05 poll scs", 32'(scs_rises), 32'd2);
    run_cmd("read 05", OP_READ, 6'h05, '0, 16'hA55A, 1'b0, 1'b1);

    run_cmd("wral", OP_WRAL, '0, 16'h1234, '0, 1'b0, 1'b0);
    run_cmd("read 00", OP_READ, 6'h00, '0, 16'h1234, 1'b0, 1'b1);
    run_cmd("read 3F", OP_READ, 6'h3F, '0, 16'h1234, 1'b0, 1'b1);
    run_cmd("erase 10", OP_ERASE, 6'h10, '0, '0, 1'b0, 1'b0);
    run_cmd("read 10", OP_READ, 6'h10, '0, 16'hFFFF, 1'b0, 1'b1);

    run_cmd("reserved", OP_RSVD, 6'h01, '0, 16'hFFFF, 1'b1, 1'b1);
    check_output("reserved latency", 32'(lat), 32'd1);
    check_output("reserved scs", 32'(scs_rises), 32'd0);

    sb.push_back('{dout: 16'h1234, err: 1'b0, chk: 1'b1});
    apply_stimulus(OP_READ, 6'h3F, '0);
    cmd_op   = OP_WRITE;
    cmd_addr = 6'h01;
    wait_done("busy read", 50);
    check_output("busy read pulses", 32'(rise_cnt), 32'd25);
    extra_done = 0;
    repeat (300) begin
      @(negedge clk);
      if (cmd_done) extra_done++;
    end
    check_output("busy extra done", 32'(extra_done), 32'd0);

    sdo_force0 = 1'b1;
    run_cmd("timeout", OP_WRITE, 6'h07, 16'h0F0F, '0, 1'b1, 1'b0);
    check_output("timeout latency", 32'(lat), 32'(25 * 2 * CLKDIV + CLKDIV + TIMEOUT + 2));
    check_output("timeout poll scs", 32'(scs_rises), 32'd2);
    check_output("timeout scs low", 32'(scs), 0);
    check_output("timeout sclk low", 32'(sclk), 0);
    check_output("timeout sdi low", 32'(sdi), 0);
    sdo_force0 = 1'b0;
    repeat (40) @(negedge clk);

    apply_stimulus(OP_WRITE, 6'h09, 16'hBEEF);
    repeat (120) @(negedge clk);
    check_output("abort scs before", 32'(scs), 1);
    rst = 1'b1;
    #1;
    check_output("abort scs", 32'(scs), 0);
    check_output("abort sclk", 32'(sclk), 0);
    check_output("abort sdi", 32'(sdi), 0);
    check_output("abort busy", 32'(cmd_busy), 0);
    @(negedge clk);
    rst = 1'b0;
    extra_done = 0;
    repeat (60) begin
      @(negedge clk);
      if (cmd_done) extra_done++;
    end
    check_output("abort no done", 32'(extra_done), 32'd0);
    run_cmd("read 10 after abort", OP_READ, 6'h10, '0, 16'hFFFF, 1'b0, 1'b1);
    run_cmd("read 09 after abort", OP_READ, 6'h09, '0, 16'h1234, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
